// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the UART config command master.
// State encoding, register addresses and response status codes.
package uart_cfg_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_DEFAULTS = 4'h0;
    localparam logic [3:0] ADDR_PARITY   = 4'h9;
    localparam logic [3:0] ADDR_PTYPE    = 4'hA;
    localparam logic [3:0] ADDR_STOP     = 4'hB;
    localparam logic [3:0] ADDR_FLEN     = 4'hC;

    localparam logic [3:0] READ_CMD = 4'hF;

    localparam logic [3:0] ST_WR_OK    = 4'h0;
    localparam logic [3:0] ST_RD_OK    = 4'h1;
    localparam logic [3:0] ST_TIMEOUT  = 4'hE;
    localparam logic [3:0] ST_BAD_ADDR = 4'hF;

    function automatic logic is_legal(input logic [3:0] a);
        return (a == ADDR_DEFAULTS) || (a == ADDR_PARITY) ||
               (a == ADDR_PTYPE)    || (a == ADDR_STOP)   ||
               (a == ADDR_FLEN);
    endfunction

endpackage

// File: rtl/uart_cfg_master_if.sv
// Command, register-access and response signals of the config master.
// master = the command initiator, slave = the RX/regfile/TX side.
interface uart_cfg_master_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       reg_valid;
    logic [3:0] reg_address;
    logic [3:0] reg_data;
    logic       reg_ack;
    logic       reg_data_out_valid;
    logic [3:0] reg_data_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_byte;

    modport master (
        input  cmd_valid, cmd_byte,
        input  reg_ack, reg_data_out_valid, reg_data_out,
        input  rsp_ready,
        output cmd_ready, reg_valid, reg_address, reg_data,
        output rsp_valid, rsp_byte
    );

    modport slave (
        output cmd_valid, cmd_byte,
        output reg_ack, reg_data_out_valid, reg_data_out,
        output rsp_ready,
        input  cmd_ready, reg_valid, reg_address, reg_data,
        input  rsp_valid, rsp_byte
    );

endinterface

// File: rtl/uart_cfg_master.sv
// Turns UART command bytes into single register accesses and
// returns one status/payload response byte per command.
module uart_cfg_master
    import uart_cfg_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic              clk_16bd,
    input  logic              rst,
    uart_cfg_master_if.master bus,
    output logic              busy
);

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_addr;
    logic [3:0] r_data;
    logic [7:0] r_rsp;
    logic       r_cmd_ready;
    logic       r_reg_valid;
    logic       r_rsp_valid;
    logic       r_busy;

    state_t     w_state;
    logic [3:0] w_cnt;
    logic [3:0] w_cnt_inc;
    logic [3:0] w_addr;
    logic [3:0] w_data;
    logic [7:0] w_rsp;
    logic [7:0] w_ack_rsp;
    logic       w_rd_ok;

    // Restore-defaults always reports the latched data, never read data.
    assign w_rd_ok = bus.reg_data_out_valid &&
                     (r_addr != ADDR_DEFAULTS);

    always_comb begin
        w_ack_rsp = {ST_WR_OK, r_data};
        unique case (1'b1)
            w_rd_ok: w_ack_rsp = {ST_RD_OK, bus.reg_data_out};
            default: w_ack_rsp = {ST_WR_OK, r_data};
        endcase
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_addr    = r_addr;
        w_data    = r_data;
        w_rsp     = r_rsp;
        w_cnt_inc = r_cnt + 4'd1;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_addr = bus.cmd_byte[7:4];
                    w_data = bus.cmd_byte[3:0];
                    if (is_legal(bus.cmd_byte[7:4])) begin
                        w_state = S_ISSUE;
                    end else begin
                        w_state = S_RESP;
                        w_rsp   = {ST_BAD_ADDR, bus.cmd_byte[7:4]};
                    end
                end
            end
            S_ISSUE: begin
                w_cnt   = '0;
                w_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                w_cnt = w_cnt_inc;
                // Ack is checked first so it wins over a same-cycle timeout.
                if (bus.reg_ack) begin
                    w_state = S_RESP;
                    w_rsp   = w_ack_rsp;
                end else if (w_cnt_inc == TMO) begin
                    w_state = S_RESP;
                    w_rsp   = {ST_TIMEOUT, r_addr};
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_16bd or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp       <= '0;
            r_cmd_ready <= 1'b1;
            r_reg_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_addr      <= w_addr;
            r_data      <= w_data;
            r_rsp       <= w_rsp;
            r_cmd_ready <= (w_state == S_IDLE);
            r_reg_valid <= (w_state == S_ISSUE);
            r_rsp_valid <= (w_state == S_RESP);
            r_busy      <= (w_state != S_IDLE);
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.reg_valid   = r_reg_valid;
    assign bus.reg_address = r_addr;
    assign bus.reg_data    = r_data;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_byte    = r_rsp;
    assign busy            = r_busy;

endmodule

// File: tb/tb_uart_cfg_master.sv
// Bench for uart_cfg_master with a behavioural register file responder
// and a transaction-level model of the expected responses.
module tb_uart_cfg_master;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    uart_cfg_master_if bus();

    uart_cfg_master #(.TIMEOUT(TO)) dut (
        .clk_16bd(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] dflt(input int i);
        if (i == 9) return 4'h1;
        if (i == 12) return 4'h8;
        return 4'h0;
    endfunction

    // Register file responder: acks one cycle after each strobe.
    logic       ack_en  = 1'b1;
    logic       inj_ack = 1'b0;
    logic       rf_up   = 1'b0;
    logic       rf_ack  = 1'b0;
    logic       rf_dv   = 1'b0;
    logic [3:0] rf_do   = 4'h0;
    logic [3:0] rf [16];

    always @(posedge clk) begin
        rf_ack <= 1'b0;
        rf_dv  <= 1'b0;
        if (!rf_up) begin
            for (int i = 0; i < 16; i++) rf[i] <= dflt(i);
            rf_up <= 1'b1;
        end else if (bus.reg_valid && ack_en) begin
            rf_ack <= 1'b1;
            if (bus.reg_address == 4'h0) begin
                for (int i = 0; i < 16; i++) rf[i] <= dflt(i);
            end else if (bus.reg_data == 4'hF) begin
                rf_dv <= 1'b1;
                rf_do <= rf[bus.reg_address];
            end else begin
                rf[bus.reg_address] <= bus.reg_data;
            end
        end
    end

    assign bus.reg_ack            = rf_ack | inj_ack;
    assign bus.reg_data_out_valid = rf_dv;
    assign bus.reg_data_out       = rf_do;

    // Transaction model and per-cycle compare.
    int         cyc = 0;
    logic       mdl_up = 1'b0;
    logic       pend_reg = 1'b0;
    logic       pend_rsp = 1'b0;
    logic       rsp_act = 1'b0;
    logic       hs_prev = 1'b0;
    int         reg_cyc = 0;
    int         rsp_cyc = 0;
    int         last_rv = -10;
    int         n_rsp = 0;
    int         n_acc = 0;
    logic [3:0] x_addr = 4'h0;
    logic [3:0] x_data = 4'h0;
    logic [7:0] x_rsp = 8'h00;
    logic [7:0] held = 8'h00;
    logic [7:0] last_rsp = 8'h00;
    logic [3:0] mdl [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model(input logic [7:0] b);
        logic [3:0] a;
        logic [3:0] d;
        a = b[7:4];
        d = b[3:0];
        n_acc++;
        if (!(a inside {4'h0, 4'h9, 4'hA, 4'hB, 4'hC})) begin
            x_rsp   = {4'hF, a};
            rsp_cyc = cyc + 1;
        end else begin
            pend_reg = 1'b1;
            reg_cyc  = cyc + 1;
            x_addr   = a;
            x_data   = d;
            if (!ack_en) begin
                x_rsp   = {4'hE, a};
                rsp_cyc = cyc + 2 + TO;
            end else begin
                rsp_cyc = cyc + 3;
                if (a == 4'h0) begin
                    x_rsp = {4'h0, d};
                    for (int i = 0; i < 16; i++) mdl[i] = dflt(i);
                end else if (d == 4'hF) begin
                    x_rsp = {4'h1, mdl[a]};
                end else begin
                    x_rsp  = {4'h0, d};
                    mdl[a] = d;
                end
            end
        end
        pend_rsp = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!mdl_up) begin
            for (int i = 0; i < 16; i++) mdl[i] = dflt(i);
            mdl_up = 1'b1;
        end
        if (rst) begin
            pend_reg = 1'b0;
            pend_rsp = 1'b0;
            rsp_act  = 1'b0;
            hs_prev  = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("post_hs_rsp_valid", bus.rsp_valid, 0);
                chk("post_hs_cmd_ready", bus.cmd_ready, 1);
                hs_prev = 1'b0;
            end
            chk("busy_vs_ready", busy, !bus.cmd_ready);
            if (bus.reg_valid) begin
                chk("reg_valid_expected", pend_reg, 1);
                if (pend_reg) begin
                    chk("reg_valid_cycle", cyc, reg_cyc);
                    chk("reg_address", bus.reg_address, x_addr);
                    chk("reg_data", bus.reg_data, x_data);
                end
                chk("reg_valid_spacing", (cyc - last_rv) >= 2, 1);
                last_rv  = cyc;
                pend_reg = 1'b0;
            end else if (pend_reg && cyc > reg_cyc) begin
                chk("reg_valid_missing", 0, 1);
                pend_reg = 1'b0;
            end
            if (bus.rsp_valid) begin
                if (!rsp_act) begin
                    chk("rsp_expected", pend_rsp, 1);
                    if (pend_rsp) begin
                        chk("rsp_cycle", cyc, rsp_cyc);
                        chk("rsp_byte", bus.rsp_byte, x_rsp);
                    end
                    held     = bus.rsp_byte;
                    last_rsp = bus.rsp_byte;
                    rsp_act  = 1'b1;
                    pend_rsp = 1'b0;
                end else begin
                    chk("rsp_stable", bus.rsp_byte, held);
                end
                chk("rsp_cmd_ready_low", bus.cmd_ready, 0);
                if (bus.rsp_ready) begin
                    rsp_act = 1'b0;
                    hs_prev = 1'b1;
                    n_rsp++;
                end
            end else if (pend_rsp && cyc > rsp_cyc) begin
                chk("rsp_missing", 0, 1);
                pend_rsp = 1'b0;
            end
            if (bus.cmd_valid && bus.cmd_ready) model(bus.cmd_byte);
        end
    end

    task automatic chk_reset();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_reg_valid", bus.reg_valid, 0);
        chk("rst_reg_address", bus.reg_address, 0);
        chk("rst_reg_data", bus.reg_data, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_byte", bus.rsp_byte, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #1;
            if (bus.cmd_ready) break;
        end
        if (!bus.cmd_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int t0;
        bit ok;
        t0 = n_rsp;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (n_rsp != t0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_wait", ok, 1);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("valid_wait", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        bit ok;
        bus.cmd_valid = 1'b0;
        bus.cmd_byte  = 8'h00;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(8'h90);
        wait_rsp();
        chk("wr_parity_rsp", last_rsp, 8'h00);
        chk("wr_parity_rf", rf[9], 4'h0);

        send(8'hCF);
        wait_rsp();
        chk("rd_flen_default", last_rsp, 8'h18);
        send(8'hC7);
        wait_rsp();
        chk("wr_flen_rsp", last_rsp, 8'h07);
        send(8'hCF);
        wait_rsp();
        chk("rd_flen_new", last_rsp, 8'h17);

        send(8'h35);
        wait_rsp();
        chk("bad_addr_rsp", last_rsp, 8'hF3);

        ack_en = 1'b0;
        bus.rsp_ready = 1'b0;
        send(8'hA1);
        wait_valid();
        @(posedge clk);
        #1;
        inj_ack = 1'b1;
        @(posedge clk);
        #1;
        inj_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_ack_rsp_byte", bus.rsp_byte, 8'hEA);
        chk("late_ack_rsp_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        wait_rsp();
        chk("timeout_rsp", last_rsp, 8'hEA);
        ack_en = 1'b1;

        @(posedge clk);
        #1;
        inj_ack = 1'b1;
        @(posedge clk);
        #1;
        inj_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_rsp_valid", bus.rsp_valid, 0);

        bus.rsp_ready = 1'b0;
        send(8'hB1);
        wait_valid();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = 8'hBF;
        a0 = n_acc;
        repeat (10) begin
            @(posedge clk);
            #2;
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        chk("bp_not_consumed", n_acc, a0);
        bus.rsp_ready = 1'b1;
        wait_rsp();
        chk("bp_first_rsp", last_rsp, 8'h01);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (n_acc != a0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk("bp_second_accept", ok, 1);
        bus.cmd_valid = 1'b0;
        wait_rsp();
        chk("bp_second_rsp", last_rsp, 8'h11);

        ack_en = 1'b0;
        send(8'h91);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #2;
            chk("post_rst_no_rsp", bus.rsp_valid, 0);
        end
        send(8'h9F);
        wait_rsp();
        chk("post_rst_read", last_rsp, 8'h10);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cfg_master.md
Name: uart_cfg_master

Overview:
- Command-side initiator for the UART configuration register file.
- Accepts 8-bit command bytes from the UART receive path and turns each into a single-cycle register access (write, or read via data 4'hF).
- Waits for the register file's ack or read data, then emits one 8-bit response byte toward the UART transmit path.
- Sits between the RX byte stream and the config register file, on the 16x-baud clock domain.

Parameters:
- TIMEOUT, 4, cycles to wait for reg_ack after reg_valid before reporting a timeout (legal range 2..15).

Ports:
- clk_16bd  in  1  16x-baud clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  a command byte is offered.
- cmd_ready  out  1  the block can accept a command (high only in IDLE).
- cmd_byte  in  8  [7:4] register address, [3:0] data; data 4'hF means read.
- reg_valid  out  1  register access strobe, one cycle per access.
- reg_address  out  4  register address, held stable from issue until RESP.
- reg_data  out  4  write data, or 4'hF for a read.
- reg_ack  in  1  register-file acknowledge.
- reg_data_out_valid  in  1  read data present; coincides with reg_ack.
- reg_data_out  in  4  read data.
- rsp_valid  out  1  a response byte is available.
- rsp_ready  in  1  the TX path takes the response.
- rsp_byte  out  8  [7:4] status, [3:0] payload.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs are registered. On reset:
  - cmd_ready=1, reg_valid=0, reg_address=0, reg_data=0;
  - rsp_valid=0, rsp_byte=8'h00, busy=0;
  - state=IDLE, timeout counter=0.
- Reset asserted mid-transaction aborts it; no response is emitted.
- Legal addresses: 4'h0 (restore defaults), 4'h9, 4'hA, 4'hB, 4'hC.
- FSM states: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - On cmd_valid && cmd_ready, latch address and data; cmd_ready drops the next cycle.
  - Legal address -> ISSUE.
  - Illegal address -> RESP with rsp_byte={4'hF, address}; no register access is made.
- ISSUE (exactly one cycle):
  - reg_valid=1 with the latched address and data.
  - Clear the counter, go to WAIT_ACK.
- WAIT_ACK:
  - reg_valid=0; the counter increments each cycle.
  - On reg_ack -> RESP. Response byte:
    - reg_data_out_valid=1 -> {4'h1, reg_data_out} (read OK);
    - otherwise -> {4'h0, latched data} (write OK).
  - Address 4'h0 always reports {4'h0, latched data}.
  - If the counter reaches TIMEOUT without ack -> RESP with {4'hE, address}.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP:
  - rsp_valid=1 and rsp_byte held stable until rsp_ready.
  - On rsp_valid && rsp_ready -> IDLE. rsp_valid is 0 and cmd_ready is 1 in the following cycle.
- Nominal latency: register file acks one cycle after reg_valid.
  - Accept at cycle N, reg_valid at N+1, reg_ack at N+2, rsp_valid at N+3.
- reg_ack seen outside WAIT_ACK is ignored.
- A late ack arriving after a timeout must not alter the pending response.
- cmd_valid while not ready: the byte is not consumed; the sender holds it.
- Back-to-back commands: the next command is accepted no earlier than the cycle after the response handshake. This guarantees reg_valid pulses are spaced ≥2 cycles apart, which the register file's one-cycle cooldown needs.

Decomposition:
- Shared package uart_cfg_pkg holds:
  - state encoding (2 bits);
  - address constants ADDR_DEFAULTS=4'h0, ADDR_PARITY=4'h9, ADDR_PTYPE=4'hA, ADDR_STOP=4'hB, ADDR_FLEN=4'hC;
  - READ_CMD=4'hF;
  - status codes ST_WR_OK=4'h0, ST_RD_OK=4'h1, ST_TIMEOUT=4'hE, ST_BAD_ADDR=4'hF.
- No sub-module needed; FSM and timeout counter live in one module.
- The bench instantiates uart_cfg_master together with the register file as the responder.

Test Plan:
- Write: after reset, cmd_byte=8'h90 -> reg_valid one cycle with address 9 and data 0; rsp_byte=8'h00 three cycles after accept; register file parity output becomes 0.
- Read: cmd 8'hCF after reset -> rsp_byte=8'h18 (frame_length 8); then cmd 8'hC7 followed by 8'hCF -> rsp_byte=8'h17.
- Illegal address: cmd 8'h35 -> no reg_valid pulse; rsp_byte=8'hF3.
- Timeout: reg_ack tied 0 with TIMEOUT=4, cmd 8'hA1 -> rsp_byte=8'hE A (=8'hEA) after 4 WAIT_ACK cycles; a late ack afterwards is ignored.
- Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and rsp_byte stay stable and cmd_ready=0 throughout; a second cmd_valid is not consumed until the handshake.
- Reset mid-WAIT_ACK: assert rst -> all outputs return to reset values immediately; no rsp_valid afterwards; the next command completes normally.
